// File: rtl/boot_pkg.sv
// boot_pkg: definitions shared by boot_sequencer and pc_stall_detector.
//   state_t      - sequencer state encoding (3 bits, IDLE = 0)
//   status_t     - registered Moore status flags, one set per state
//   HALT_CYCLES_DEF / MAX_CYCLES_DEF - parameter defaults
//   addr_w()     - write-address width for a given memory depth
package boot_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_RELEASE = 3'd2,
        S_RUN     = 3'd3,
        S_HALTED  = 3'd4
    } state_t;

    localparam int HALT_CYCLES_DEF = 4;
    localparam int MAX_CYCLES_DEF  = 1024;

    typedef struct packed {
        logic load_ready;
        logic busy;
        logic done;
    } status_t;

    // Width of an address into a DEPTH-word memory; never below 1 bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Status flags that hold while the FSM sits in state s. They are
    // loaded together with the state so every flag is a flop output.
    function automatic status_t status_of(input state_t s);
        status_t f;
        f.load_ready = (s == S_LOAD);
        f.busy       = (s == S_LOAD) || (s == S_RELEASE) || (s == S_RUN);
        f.done       = (s == S_HALTED);
        return f;
    endfunction

endpackage

// File: rtl/pc_stall_detector.sv
// pc_stall_detector: watches the core PC while the sequencer is in RUN and
// flags a branch-to-self.
//   clk, rst     - clock, asynchronous active-low reset
//   enable       - high while the sequencer is in RUN
//   pc_in        - the core's current PC
//   halted       - high on the RUN edge at which stable_cnt reaches
//                  HALT_CYCLES-1; the sequencer leaves RUN on that edge
module pc_stall_detector
    import boot_pkg::*;
#(
    parameter int AW          = 6,
    parameter int HALT_CYCLES = HALT_CYCLES_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [AW-1:0] pc_in,
    output logic          halted
);

    localparam int CW = $clog2(HALT_CYCLES) + 1;

    logic [AW-1:0] pc_prev;
    logic [CW-1:0] stable_cnt;
    logic          armed;   // set after the first RUN edge; pc_prev is valid
    logic          match;

    // The first RUN edge has no previous PC to compare against.
    assign match  = armed && (pc_in == pc_prev);
    // Combinational so the FSM leaves RUN on the same edge the count
    // would reach HALT_CYCLES-1.
    assign halted = enable && match && (stable_cnt == CW'(HALT_CYCLES - 2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_prev    <= '0;
            stable_cnt <= '0;
            armed      <= 1'b0;
        end else begin
            armed <= enable;
            if (enable) begin
                pc_prev    <= pc_in;
                stable_cnt <= match ? stable_cnt + CW'(1) : '0;
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/boot_sequencer.sv
// boot_sequencer: loads a program into instruction memory while holding the
// core in reset, releases the core, and stops when the PC parks on a
// branch-to-self or the RUN cycle budget runs out.
//   clk, rst                 - clock, asynchronous active-low reset
//   start, abort             - begin a load / return to IDLE (abort wins)
//   load_valid/ready/data/last - program stream, one word per handshake
//   imem_we/addr/wdata       - instruction-memory write port (combinational
//                              from the handshake)
//   cpu_rst                  - active-low core reset, high only in RUN/HALTED
//   pc_in                    - core PC
//   busy, done, timeout      - LOAD/RELEASE/RUN, HALTED, budget stop
//   cycle_count              - RUN edges, saturating
module boot_sequencer
    import boot_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int DATA_W      = 32,
    parameter int HALT_CYCLES = HALT_CYCLES_DEF,
    parameter int MAX_CYCLES  = MAX_CYCLES_DEF,
    localparam int AW         = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              imem_we,
    output logic [AW-1:0]     imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_rst,
    input  logic [AW-1:0]     pc_in,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [31:0]       cycle_count
);

    state_t        state;
    status_t       status;
    logic [AW-1:0] wr_ptr;
    logic          hs;
    logic          pc_halted;

    assign {load_ready, busy, done} = status;

    assign hs         = load_valid && load_ready;
    assign imem_we    = hs;
    assign imem_addr  = wr_ptr;
    assign imem_wdata = load_data;

    pc_stall_detector #(
        .AW          (AW),
        .HALT_CYCLES (HALT_CYCLES)
    ) u_stall (
        .clk    (clk),
        .rst    (rst),
        .enable (state == S_RUN),
        .pc_in  (pc_in),
        .halted (pc_halted)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            status      <= '0;
            cpu_rst     <= 1'b0;
            wr_ptr      <= '0;
            timeout     <= 1'b0;
            cycle_count <= '0;
        end else if (abort) begin
            // wr_ptr is left as-is; the next start clears it.
            state   <= S_IDLE;
            status  <= status_of(S_IDLE);
            cpu_rst <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        state       <= S_LOAD;
                        status      <= status_of(S_LOAD);
                        cpu_rst     <= 1'b0;
                        wr_ptr      <= '0;
                        cycle_count <= '0;
                        timeout     <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (hs) begin
                        wr_ptr <= wr_ptr + AW'(1);
                        // The last slot ends the load even without load_last,
                        // so no word beyond DEPTH is ever accepted.
                        if (load_last || wr_ptr == AW'(DEPTH - 1)) begin
                            state  <= S_RELEASE;
                            status <= status_of(S_RELEASE);
                        end
                    end
                end
                S_RELEASE: begin
                    // Extra cycle keeps the core in reset while the final
                    // memory write lands.
                    state   <= S_RUN;
                    status  <= status_of(S_RUN);
                    cpu_rst <= 1'b1;
                end
                S_RUN: begin
                    // Halt outranks the budget; the leaving edge is not counted.
                    if (pc_halted) begin
                        state   <= S_HALTED;
                        status  <= status_of(S_HALTED);
                        timeout <= 1'b0;
                    end else if (cycle_count == 32'(MAX_CYCLES - 1)) begin
                        state   <= S_HALTED;
                        status  <= status_of(S_HALTED);
                        timeout <= 1'b1;
                    end else if (cycle_count != '1) begin
                        cycle_count <= cycle_count + 32'd1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    status  <= status_of(S_IDLE);
                    cpu_rst <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boot_sequencer.sv
// tb_boot_sequencer: drives boot_sequencer with a tiny behavioural core
// (branch opcode 6'b000100 with a 16-bit word offset, everything else
// falls through to pc+1). Memory writes are scoreboarded: every word the
// bench offers in LOAD is queued with its expected address, and a negedge
// monitor pops and compares each DUT write.
module tb_boot_sequencer;

    localparam int DEPTH       = 64;
    localparam int DATA_W      = 32;
    localparam int HALT_CYCLES = 4;
    localparam int MAX_CYCLES  = 16;
    // Short program: first fetch 1 edge after RUN entry, PC reaches 2 one
    // edge later, the self-branch re-selects 2 on the third edge, then
    // HALT_CYCLES-1 more edges to flag it.
    localparam int SHORT_DONE_EDGES = 3 + (HALT_CYCLES - 1);

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start, abort;
    logic              load_valid, load_ready, load_last;
    logic [DATA_W-1:0] load_data;
    logic              imem_we;
    logic [5:0]        imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              cpu_rst;
    logic [5:0]        pc;
    logic              busy, done, timeout;
    logic [31:0]       cycle_count;

    int   n_cmp = 0;
    int   n_bad = 0;
    wr_t  sb[$];
    wr_t  exp_wr;
    logic [5:0] exp_ptr;
    logic [31:0] mem [0:DEPTH-1];

    boot_sequencer #(
        .DEPTH(DEPTH), .DATA_W(DATA_W),
        .HALT_CYCLES(HALT_CYCLES), .MAX_CYCLES(MAX_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_last(load_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst), .pc_in(pc),
        .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // Instruction memory and the core.
    always @(posedge clk) if (imem_we) mem[imem_addr] <= imem_wdata;

    always @(posedge clk or negedge cpu_rst) begin
        if (!cpu_rst)                          pc <= '0;
        else if (mem[pc][31:26] == 6'b000100) pc <= pc + 6'd1 + mem[pc][5:0];
        else                                   pc <= pc + 6'd1;
    end

    // Scoreboard consumer.
    always @(negedge clk) begin
        if (rst && imem_we) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write addr=%0d data=%h", imem_addr, imem_wdata);
            end else begin
                exp_wr = sb.pop_front();
                if (imem_addr !== exp_wr.addr || imem_wdata !== exp_wr.data) begin
                    n_bad++;
                    $display("FAIL imem_write got addr=%0d data=%h want addr=%0d data=%h",
                             imem_addr, imem_wdata, exp_wr.addr, exp_wr.data);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_start();
        start = 1'b1; step(); start = 1'b0;
        exp_ptr = '0;
    endtask

    task automatic push_word(input logic [31:0] d, input logic last);
        load_valid = 1'b1; load_data = d; load_last = last;
        sb.push_back('{addr: exp_ptr, data: d});
        exp_ptr++;
        step();
        load_valid = 1'b0; load_last = 1'b0;
    endtask

    task automatic load_short();
        push_word(32'h2001_0005, 1'b0);
        push_word(32'h2002_0003, 1'b0);
        push_word(32'h1000_FFFF, 1'b1);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 60) begin step(); n++; end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 0; abort = 0; load_valid = 0; load_last = 0; load_data = '0;
        exp_ptr = '0;
        #2;
        n_cmp++;
        if ({cpu_rst, load_ready, imem_we, busy, done, timeout} !== 6'b0 ||
            imem_addr !== 6'd0 || cycle_count !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_values got cpu_rst=%b rdy=%b we=%b busy=%b done=%b to=%b addr=%0d cc=%0d want all 0",
                     cpu_rst, load_ready, imem_we, busy, done, timeout, imem_addr, cycle_count);
        end
        step(); step(); rst = 1'b1; step();
        n_cmp++;
        if (busy !== 1'b0 || load_ready !== 1'b0) begin
            n_bad++; $display("FAIL idle_after_reset got busy=%b rdy=%b want 0 0", busy, load_ready);
        end
    endtask

    task automatic test_short_program();
        int n;
        do_start();
        n_cmp++;
        if (load_ready !== 1'b1 || busy !== 1'b1 || cpu_rst !== 1'b0) begin
            n_bad++; $display("FAIL short_load_entry got rdy=%b busy=%b cpu_rst=%b want 1 1 0", load_ready, busy, cpu_rst);
        end
        load_short();
        // RELEASE: core still held.
        n_cmp++;
        if (load_ready !== 1'b0 || busy !== 1'b1 || cpu_rst !== 1'b0) begin
            n_bad++; $display("FAIL short_release got rdy=%b busy=%b cpu_rst=%b want 0 1 0", load_ready, busy, cpu_rst);
        end
        step();
        n_cmp++;
        if (cpu_rst !== 1'b1 || done !== 1'b0) begin
            n_bad++; $display("FAIL short_run_entry got cpu_rst=%b done=%b want 1 0", cpu_rst, done);
        end
        n = 0;
        while (!done && n < 60) begin
            start = (n == 1);   // must be ignored in RUN
            step();
            start = 1'b0;
            n++;
            if (n == 2) begin
                n_cmp++;
                if (load_ready !== 1'b0 || busy !== 1'b1) begin
                    n_bad++; $display("FAIL start_ignored_in_run got rdy=%b busy=%b want 0 1", load_ready, busy);
                end
            end
        end
        n_cmp++;
        if (n != SHORT_DONE_EDGES) begin
            n_bad++; $display("FAIL short_halt_latency got %0d edges want %0d", n, SHORT_DONE_EDGES);
        end
        n_cmp++;
        if (timeout !== 1'b0 || cycle_count !== 32'(SHORT_DONE_EDGES - 1) || busy !== 1'b0 || cpu_rst !== 1'b1) begin
            n_bad++; $display("FAIL short_halted got to=%b cc=%0d busy=%b cpu_rst=%b want 0 %0d 0 1",
                              timeout, cycle_count, busy, cpu_rst, SHORT_DONE_EDGES - 1);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++; $display("FAIL short_writes_missing got %0d pending want 0", sb.size());
        end
    endtask

    task automatic test_full_depth();
        do_start();   // from HALTED
        n_cmp++;
        if (cpu_rst !== 1'b0 || done !== 1'b0 || load_ready !== 1'b1) begin
            n_bad++; $display("FAIL halted_restart got cpu_rst=%b done=%b rdy=%b want 0 0 1", cpu_rst, done, load_ready);
        end
        for (int i = 0; i < DEPTH; i++) begin
            push_word(32'h2000_0000 | 32'(i), 1'b0);
            if (i == DEPTH - 2) begin
                n_cmp++;
                if (load_ready !== 1'b1) begin
                    n_bad++; $display("FAIL full_before_last got rdy=%b want 1", load_ready);
                end
            end
        end
        n_cmp++;
        if (load_ready !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL full_release got rdy=%b busy=%b want 0 1", load_ready, busy);
        end
        load_valid = 1'b1; load_data = 32'hDEAD_BEEF;
        @(negedge clk);
        n_cmp++;
        if (imem_we !== 1'b0) begin
            n_bad++; $display("FAIL full_overflow_write got we=%b want 0", imem_we);
        end
        load_valid = 1'b0;
        abort = 1'b1; step(); abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || cpu_rst !== 1'b0 || sb.size() != 0) begin
            n_bad++; $display("FAIL full_abort got busy=%b cpu_rst=%b pending=%0d want 0 0 0", busy, cpu_rst, sb.size());
        end
    endtask

    task automatic test_budget();
        int n;
        do_start();
        for (int i = 0; i < 4; i++) push_word(32'h2000_0010 + 32'(i), i == 3);
        step();   // RELEASE -> RUN
        n = 0;
        while (!done && n < 60) begin
            step(); n++;
            if (n == 8) begin
                n_cmp++;
                if (cycle_count !== 32'd8) begin
                    n_bad++; $display("FAIL budget_midcount got %0d want 8", cycle_count);
                end
            end
        end
        n_cmp++;
        if (n != MAX_CYCLES || timeout !== 1'b1 || cycle_count !== 32'(MAX_CYCLES - 1)) begin
            n_bad++; $display("FAIL budget_stop got edges=%0d to=%b cc=%0d want %0d 1 %0d",
                              n, timeout, cycle_count, MAX_CYCLES, MAX_CYCLES - 1);
        end
    endtask

    task automatic test_gapped_valid();
        do_start();
        n_cmp++;
        if (timeout !== 1'b0 || cycle_count !== 32'd0 || done !== 1'b0) begin
            n_bad++; $display("FAIL start_clears got to=%b cc=%0d done=%b want 0 0 0", timeout, cycle_count, done);
        end
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) push_word(32'h2000_0100 + 32'(i), 1'b0);
            else begin
                load_valid = 1'b0; load_data = 32'hBAD0_0000 + 32'(i);
                @(negedge clk);
                n_cmp++;
                if (imem_we !== 1'b0) begin
                    n_bad++; $display("FAIL gap_write got we=%b want 0", imem_we);
                end
                step();
            end
        end
        push_word(32'h2000_0200, 1'b1);   // must land at address 2
        n_cmp++;
        if (sb.size() != 0 || load_ready !== 1'b0) begin
            n_bad++; $display("FAIL gapped_end got pending=%0d rdy=%b want 0 0", sb.size(), load_ready);
        end
        abort = 1'b1; step(); abort = 1'b0;
    endtask

    task automatic test_abort_start();
        int n;
        do_start();
        push_word(32'h2000_0300, 1'b0);
        push_word(32'h2000_0301, 1'b0);
        start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
        step();
        n_cmp++;
        if (busy !== 1'b0 || load_ready !== 1'b0 || cpu_rst !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL abort_beats_start got busy=%b rdy=%b cpu_rst=%b done=%b want 0 0 0 0",
                              busy, load_ready, cpu_rst, done);
        end
        do_start();
        load_short();
        step();
        wait_done(n);
        n_cmp++;
        if (n != SHORT_DONE_EDGES || sb.size() != 0 || cycle_count !== 32'(SHORT_DONE_EDGES - 1)) begin
            n_bad++; $display("FAIL abort_reload got edges=%0d pending=%0d cc=%0d want %0d 0 %0d",
                              n, sb.size(), cycle_count, SHORT_DONE_EDGES, SHORT_DONE_EDGES - 1);
        end
    endtask

    task automatic test_async_reset();
        int n;
        do_start();
        load_short();
        step(); step(); step();   // two edges into RUN
        #3;
        rst = 1'b0; load_valid = 1'b1;
        #1;
        n_cmp++;
        if ({cpu_rst, load_ready, imem_we, busy, done, timeout} !== 6'b0 ||
            imem_addr !== 6'd0 || cycle_count !== 32'd0) begin
            n_bad++;
            $display("FAIL async_reset got cpu_rst=%b rdy=%b we=%b busy=%b done=%b to=%b addr=%0d cc=%0d want all 0",
                     cpu_rst, load_ready, imem_we, busy, done, timeout, imem_addr, cycle_count);
        end
        load_valid = 1'b0;
        step(); rst = 1'b1; step();
        do_start();
        load_short();
        step();
        wait_done(n);
        n_cmp++;
        if (n != SHORT_DONE_EDGES || timeout !== 1'b0 || sb.size() != 0) begin
            n_bad++; $display("FAIL post_reset_reload got edges=%0d to=%b pending=%0d want %0d 0 0",
                              n, timeout, sb.size(), SHORT_DONE_EDGES);
        end
    endtask

    initial begin
        test_reset();
        test_short_program();
        test_full_depth();
        test_budget();
        test_gapped_valid();
        test_abort_start();
        test_async_reset();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
